// File: rtl/cmul_pkg.sv
// ============================================================================
// Module      : cmul_pkg
// Description : Shared widths, requester count and priority encoding for the
//               complex-multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmul_pkg;

  localparam int DATA_W  = 16;
  localparam int PART_W  = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

endpackage

`default_nettype wire

// File: rtl/complex_mul.sv
// ============================================================================
// Module      : complex_mul
// Description : Combinational complex multiply on packed {real, imag} words,
//               each part wrapped to PART_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_mul
  import cmul_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_prod
);

  logic signed [PART_W-1:0] w_ar, w_ai, w_br, w_bi;
  logic        [PART_W-1:0] w_re, w_im;

  assign w_ar = i_a[DATA_W-1:PART_W];
  assign w_ai = i_a[PART_W-1:0];
  assign w_br = i_b[DATA_W-1:PART_W];
  assign w_bi = i_b[PART_W-1:0];

  // Low PART_W bits of a product/sum depend only on low PART_W bits of the
  // operands, so evaluating at PART_W width yields the truncated result.
  assign w_re = w_ar * w_br - w_ai * w_bi;
  assign w_im = w_ar * w_bi + w_ai * w_br;

  assign o_prod = {w_re, w_im};

endmodule

`default_nettype wire

// File: rtl/cmul_arbiter.sv
// ============================================================================
// Module      : cmul_arbiter
// Description : Round-robin arbiter sharing one complex_mul between two
//               requesters through a two-stage valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmul_arbiter #(
  parameter int NUM_REQ = cmul_pkg::NUM_REQ,
  parameter int DATA_W  = cmul_pkg::DATA_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req_valid,
  output logic [NUM_REQ-1:0] o_req_ready,
  input  logic [DATA_W-1:0]  i_A0,
  input  logic [DATA_W-1:0]  i_B0,
  input  logic [DATA_W-1:0]  i_A1,
  input  logic [DATA_W-1:0]  i_B1,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_prod,
  output logic               o_id,
  output logic               o_busy
);

  import cmul_pkg::*;

  pri_e              pri_q, pri_d;
  logic              s1_valid_q, s1_id_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic              s2_valid_q, s2_id_q;
  logic [DATA_W-1:0] s2_prod_q;

  logic              w_gnt_id, w_gnt_any, w_s2_adv, w_s1_acc, w_hs;
  logic [DATA_W-1:0] w_mul;

  assign w_gnt_any = |i_req_valid;
  assign w_s2_adv  = !s2_valid_q || i_ready;
  assign w_s1_acc  = !s1_valid_q || w_s2_adv;
  // Reset gating keeps ready low even in the very cycle reset is asserted.
  assign w_hs      = w_gnt_any && w_s1_acc && i_rst_n;

  always_comb begin
    w_gnt_id = 1'b0;
    case (i_req_valid[1:0])
      2'b01:   w_gnt_id = 1'b0;
      2'b10:   w_gnt_id = 1'b1;
      2'b11:   w_gnt_id = (pri_q == PRI1);
      default: w_gnt_id = 1'b0;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    pri_d       = pri_q;
    if (w_hs) begin
      o_req_ready[w_gnt_id] = 1'b1;
      pri_d                 = w_gnt_id ? PRI0 : PRI1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pri_q <= PRI0;
    else          pri_q <= pri_d;
  end

  complex_mul u_complex_mul (
    .i_a    (s1_a_q),
    .i_b    (s1_b_q),
    .o_prod (w_mul)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      if (w_s2_adv) begin
        s2_valid_q <= s1_valid_q;
        s2_id_q    <= s1_id_q;
        s2_prod_q  <= w_mul;
      end
      if (w_hs) begin
        s1_valid_q <= 1'b1;
        s1_id_q    <= w_gnt_id;
        s1_a_q     <= w_gnt_id ? i_A1 : i_A0;
        s1_b_q     <= w_gnt_id ? i_B1 : i_B0;
      end else if (w_s2_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign o_valid = s2_valid_q;
  assign o_prod  = s2_prod_q;
  assign o_id    = s2_id_q;
  assign o_busy  = s1_valid_q || s2_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cmul_arbiter.sv
// ============================================================================
// Module      : tb_cmul_arbiter
// Description : Randomized and directed bench for cmul_arbiter against a
//               queue-based reference model of the arbiter and pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] a0, b0, a1, b1;
  logic        out_valid, ready, out_id, busy;
  logic [15:0] prod;

  always #5 clk = ~clk;

  cmul_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_A0        (a0),
    .i_B0        (b0),
    .i_A1        (a1),
    .i_B1        (b1),
    .o_valid     (out_valid),
    .i_ready     (ready),
    .o_prod      (prod),
    .o_id        (out_id),
    .o_busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: ordered list of in-flight products; the head may be at
  // the output, and at most one more item waits behind it.
  typedef struct {
    logic [15:0] p;
    logic        id;
    bit          at_out;
  } ent_t;

  ent_t q[$];
  bit   m_pri;

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ar, ai, br, bi, re, im;
    logic [31:0] r, i;
    ar = $signed(a[15:8]); ai = $signed(a[7:0]);
    br = $signed(b[15:8]); bi = $signed(b[7:0]);
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    r = re; i = im;
    return {r[7:0], i[7:0]};
  endfunction

  task automatic cycle(input logic [1:0] v, input logic rdy,
                       input logic [15:0] ia0, input logic [15:0] ib0,
                       input logic [15:0] ia1, input logic [15:0] ib1,
                       output logic [1:0] seen);
    bit presented, s1_full, adv, acc, hs, g;
    logic [1:0] exp_rdy;
    ent_t e;
    req_valid = v; ready = rdy; a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
    #1;
    presented = (q.size() > 0) && q[0].at_out;
    s1_full   = (q.size() == 2) || (q.size() == 1 && !q[0].at_out);
    adv       = !presented || rdy;
    acc       = !s1_full || adv;
    g         = (v == 2'b11) ? m_pri : v[1];
    hs        = (v != 2'b00) && acc;
    exp_rdy   = hs ? (g ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    check("o_valid", {31'd0, out_valid}, {31'd0, presented});
    check("o_busy", {31'd0, busy}, {31'd0, q.size() > 0});
    if (presented) begin
      check("o_prod", {16'd0, prod}, {16'd0, q[0].p});
      check("o_id", {31'd0, out_id}, {31'd0, q[0].id});
    end
    seen = req_ready;
    @(posedge clk);
    if (presented && rdy) void'(q.pop_front());
    if (adv && q.size() > 0 && !q[0].at_out) q[0].at_out = 1'b1;
    if (hs) begin
      e.p = g ? ref_mul(ia1, ib1) : ref_mul(ia0, ib0);
      e.id = g;
      e.at_out = 1'b0;
      q.push_back(e);
      m_pri = !g;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b11; ready = 1'b1;
    #1;
    check("rst_ready_first", {30'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    q.delete(); m_pri = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_prod", {16'd0, prod}, 32'd0);
    check("rst_id", {31'd0, out_id}, 32'd0);
    rst_n = 1'b1;
  endtask

  logic [1:0]  seen;
  logic [15:0] held;
  int          g0, g1;

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(posedge clk); #1;
    do_reset();

    // Single request latency
    cycle(2'b01, 1'b1, 16'h0402, 16'h02FF, 16'h1234, 16'h5678, seen);
    cycle(2'b00, 1'b1, 16'hAAAA, 16'h5555, 16'h1111, 16'h2222, seen);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_prod", {16'd0, prod}, 32'h0A00);
    check("single_id", {31'd0, out_id}, 32'd0);
    cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);

    // Contention from reset
    do_reset();
    cycle(2'b11, 1'b1, 16'h0402, 16'h02FF, 16'hFFFE, 16'hFE05, seen);
    check("cont_grant0", {30'd0, seen}, 32'd1);
    cycle(2'b11, 1'b1, 16'h0402, 16'h02FF, 16'hFFFE, 16'hFE05, seen);
    check("cont_grant1", {30'd0, seen}, 32'd2);
    cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);
    check("cont_prod0", {16'd0, prod}, 32'h0CFF);
    check("cont_id1", {31'd0, out_id}, 32'd1);
    cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);

    // Fairness
    do_reset();
    g0 = 0; g1 = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(2'b11, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), seen);
      check("fair_order", {30'd0, seen}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (seen == 2'b01) g0++;
      if (seen == 2'b10) g1++;
    end
    check("fair_cnt0", g0, 32'd4);
    check("fair_cnt1", g1, 32'd4);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);

    // Backpressure
    cycle(2'b11, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), seen);
    cycle(2'b11, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), seen);
    held = prod;
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), seen);
      check("bp_hold", {16'd0, prod}, {16'd0, held});
      check("bp_noready", {30'd0, seen}, 32'd0);
    end
    check("bp_depth", q.size(), 32'd2);
    for (int i = 0; i < 4; i++) cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);
    check("bp_drained", {31'd0, busy}, 32'd0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++)
      cycle(2'b11, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), seen);
    do_reset();
    cycle(2'b11, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), seen);
    check("mid_rst_pri0", {30'd0, seen}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);

    // Truncation
    cycle(2'b01, 1'b1, 16'h7F7F, 16'h7F7F, 16'h0, 16'h0, seen);
    cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);
    check("trunc_prod", {16'd0, prod}, 32'h0002);
    cycle(2'b00, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, seen);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else cycle(2'($urandom), 1'($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
